// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: controller states, forward-select codes
// and the register-address width carried through the pipeline buffers.
package pipe_ctrl_pkg;

    localparam int REG_W   = 6;
    localparam int LDCNT_W = 3;   // holds LD_LAT-1 for LD_LAT up to 7

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MWAIT   = 2'd2
    } pipe_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // The EX/MEM result is younger than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit)
            return FWD_EXMEM;
        else if (wb_hit)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Operand forwarding select for the two ID-stage source registers.
// Register 0 is hard-wired zero and is never forwarded.
module fwd_unit #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);
    import pipe_ctrl_pkg::*;

    logic mem_live;
    logic wb_live;

    assign mem_live = mem_regwrite & (mem_rd != '0);
    assign wb_live  = wb_regwrite & (wb_rd != '0);

    assign fwd_a = fwd_pick(mem_live & (mem_rd == id_rs), wb_live & (wb_rd == id_rs));
    assign fwd_b = fwd_pick(mem_live & (mem_rd == id_rt), wb_live & (wb_rd == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush, load-use
// stall, operand forwarding selects and saturating stall/flush counters.
module pipe_ctrl #(
    parameter int REG_W  = pipe_ctrl_pkg::REG_W,
    parameter int LD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import pipe_ctrl_pkg::*;

    localparam logic [LDCNT_W-1:0] LD_INIT = LDCNT_W'(LD_LAT - 1);

    pipe_state_e        state_q, state_d;
    logic [LDCNT_W-1:0] cnt_q, cnt_d;
    logic               load_use;
    logic [1:0]         fwd_a_raw, fwd_b_raw;

    assign load_use = ex_is_load & id_valid & (ex_rd != '0) &
                      ((ex_rd == id_rs) | (ex_rd == id_rt));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = ST_MWAIT;
            cnt_d    = '0;
        end else if (ex_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = ST_RUN;
            cnt_d      = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        cnt_d      = LD_INIT;
                        state_d    = (LD_LAT > 1) ? ST_LDSTALL : ST_RUN;
                    end
                end
                ST_LDSTALL: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q <= LDCNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                // Exit cycle of a memory wait runs freely; any older stall is dropped.
                ST_MWAIT: state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_en && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    fwd_unit #(
        .REG_W(REG_W)
    ) u_fwd (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_a        (fwd_a_raw),
        .fwd_b        (fwd_b_raw)
    );

    assign fwd_a = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b = rst ? FWD_RF : fwd_b_raw;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter REG_W, default 6, register-address width matching the rd field carried through the pipeline buffers.
REQ-002 SHALL provide parameter LD_LAT, default 1, load-use stall length in cycles (legal range 1..7).
REQ-003 SHALL provide parameter CNT_W, default 16, width of the performance counters.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  REG_W  source registers of the instruction in the ID stage.
- id_valid  in  1  ID holds a real instruction.
- ex_rd  in  REG_W  destination register of the EX instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_taken  in  1  EX branch/jump resolved taken.
- mem_rd  in  REG_W  destination register in MEM.
- mem_regwrite  in  1  MEM instruction writes a register.
- wb_rd  in  REG_W  destination register in WB.
- wb_regwrite  in  1  WB instruction writes a register.
- mem_busy  in  1  data memory not ready this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  buffer/PC load enables.
- ifid_flush, idex_flush  out  1  load a bubble (zeros) instead of data.
- fwd_a, fwd_b  out  2  operand source for rs/rt: 00 regfile, 01 EX/MEM alu_out, 10 MEM/WB.
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.

Function
REQ-005 SHALL implement FSM states RUN, LDSTALL, MWAIT.
REQ-006 SHALL give hazard priority mem_busy > ex_taken > load-use in every state.
REQ-007 In any state, when mem_busy=1, SHALL drive all five enables to 0 and both flushes to 0, and SHALL enter MWAIT.
REQ-008 In MWAIT with mem_busy=0, SHALL return to RUN on the next edge, with all enables 1 in the exit cycle, and SHALL discard any interrupted LDSTALL.
REQ-009 In RUN with ex_taken=1 and mem_busy=0, SHALL assert ifid_flush=1 and idex_flush=1 with all enables 1 for that cycle only, then increment flush_cnt.
REQ-010 SHALL detect load-use as ex_is_load & id_valid & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
REQ-011 In RUN, when load-use is detected and no higher-priority event is active, SHALL drive pc_en=0, ifid_en=0 and idex_flush=1, load the down-counter with LD_LAT-1, and enter LDSTALL if LD_LAT>1 (otherwise stay in RUN).
REQ-012 In LDSTALL, SHALL hold pc_en=0, ifid_en=0 and idex_flush=1, decrement the counter each cycle, and return to RUN when the counter reaches 0.
REQ-013 An ex_taken seen in LDSTALL SHALL abort the stall, apply REQ-009 and go to RUN.
REQ-014 SHALL increment stall_cnt on every cycle where pc_en=0, saturating at all-ones; flush_cnt SHALL likewise saturate.
REQ-015 SHALL compute fwd_a combinationally: 01 if mem_regwrite & mem_rd!=0 & mem_rd==id_rs; else 10 if wb_regwrite & wb_rd!=0 & wb_rd==id_rs; else 00. fwd_b SHALL do the same on id_rt.
REQ-016 Enables and flushes SHALL be combinational from state, counter and current inputs (zero-cycle latency); state, counter and perf counters SHALL be registered.

Reset
REQ-017 While rst=1, SHALL force state=RUN, counter=0, stall_cnt=0, flush_cnt=0, all enables 0, both flushes 1 and fwd outputs 00.
REQ-018 Reset asserted mid-LDSTALL or mid-MWAIT SHALL abort immediately; the first cycle after release SHALL be RUN with all enables 1.

Structure
REQ-019 State encoding, the forward-select constants (FWD_RF/FWD_EXMEM/FWD_MEMWB) and REG_W SHALL live in a shared pipeline package.
REQ-020 SHALL instantiate one sub-module, fwd_unit, holding the REQ-015 logic.

Verification
REQ-021 ex_is_load=1, ex_rd=5, id_rs=5, LD_LAT=1 -> one cycle of pc_en=0 and idex_flush=1, then RUN; stall_cnt=1.
REQ-022 Same stimulus with LD_LAT=3 -> three stall cycles; ex_taken pulsed in the 2nd stall cycle -> both flushes high that cycle, RUN next cycle.
REQ-023 mem_busy high for 4 cycles during a load-use stall -> all enables 0 for 4 cycles, MWAIT, then RUN; stall_cnt +4 or more.
REQ-024 mem_rd=wb_rd=7, both regwrites set, id_rs=7, id_rt=0 -> fwd_a=01, fwd_b=00; ex_rd=0 with a load -> no stall.
REQ-025 Preload stall_cnt near saturation (0xFFFE) and stall 3 cycles -> holds 0xFFFF; asynchronous rst mid-stall -> outputs reach reset values without a clock edge.
